eth_tx_arb: RTL
===============

// Module: eth_tx_arb
// PURPOSE
//  Packet-atomic round-robin arbiter that shares the single 64-bit Ethernet TX AXI-stream
//  between NUM_SRC encapsulation sources: src0 TLP encap, src1 NetTLP cmd reply, src2 pciecfg reply.
//  Sits between the encap cores and the MAC TX interface.
//  Guarantees whole-frame ownership, fairness and a bounded frame length: over-long frames are
//  truncated with a forced tlast, and the rest of the source frame is drained.
// PARAMETERS
//  NUM_SRC    3    number of requesting sources (2..8)
//  MAX_BEATS  190  max 64-bit beats per frame (1518 B); frames reaching it are truncated
// PORTS
//  eth_clk      in   1           TX clock; all logic on rising edge
//  eth_rst_n    in   1           asynchronous active-low reset
//  s_tvalid     in   NUM_SRC     per-source beat valid
//  s_tlast      in   NUM_SRC     per-source end of frame
//  s_tkeep      in   8*NUM_SRC   per-source byte enables; src i at [8i+:8]
//  s_tdata      in   64*NUM_SRC  per-source data; src i at [64i+:64]
//  s_tready     out  NUM_SRC     per-source ready
//  m_tvalid     out  1           to MAC
//  m_tlast      out  1           to MAC
//  m_tkeep      out  8           to MAC
//  m_tdata      out  64          to MAC
//  m_tready     in   1           from MAC
//  grant        out  NUM_SRC     one-hot owner; 0 when idle
//  trunc_pulse  out  1           1-cycle pulse when a frame is truncated
//  trunc_cnt    out  16          saturating count of truncated frames
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - state=IDLE, rr_ptr=0, beat_cnt=0.
//   - grant, s_tready, m_*, trunc_pulse and trunc_cnt are all 0.
//   - Reset mid-frame abandons the frame; no tlast is emitted.
//  Handshake: a beat transfers when valid&&ready.
//   - m_tvalid never depends on m_tready.
//   - m_* stay stable while m_tvalid&&!m_tready.
//  IDLE:
//   - s_tready=0, m_tvalid=0.
//   - If any s_tvalid: winner = first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//   - Register grant=onehot(winner), beat_cnt=0, go PASS.
//   - Arbitration latency is 1 cycle: the first beat can reach m_* the cycle after the request is seen.
//  PASS:
//   - m_tvalid/m_tkeep/m_tdata = source[grant].
//   - m_tlast = s_tlast[grant] | (beat_cnt==MAX_BEATS-1).
//   - s_tready = grant & {NUM_SRC{m_tready}}; non-granted s_tready=0.
//   - Each m-handshake: beat_cnt++.
//   - Handshake with s_tlast: go IDLE, rr_ptr=(winner+1) mod NUM_SRC.
//   - Handshake at beat_cnt==MAX_BEATS-1 with !s_tlast: forced tlast emitted.
//     Then trunc_pulse=1 next cycle, trunc_cnt+=1 (saturates at 16'hFFFF), go DRAIN.
//   - Source tlast on exactly beat MAX_BEATS: normal end, no truncation.
//  DRAIN:
//   - m_tvalid=0; s_tready=grant (drops beats regardless of m_tready).
//   - On s_tvalid&&s_tlast of the owner: go IDLE, rr_ptr advances as in PASS.
//  Rotation rules:
//   - grant changes only in IDLE, never mid-frame.
//   - Requests arriving during PASS/DRAIN wait.
//   - Simultaneous requests resolve strictly by rr_ptr order, so all active sources get one
//     frame each within NUM_SRC frames.
//   - A source deasserting s_tvalid mid-frame keeps the grant (bubble passes through as m_tvalid=0).
//  Widths: beat_cnt is $clog2(MAX_BEATS+1) bits; rr_ptr is $clog2(NUM_SRC) bits, wraps at NUM_SRC-1 -> 0.
// TESTING
//  1. src0 alone, 3-beat frame, m_tready=1.
//     -> grant=001 one cycle after s_tvalid; 3 beats out, last with m_tlast=1; grant=000; rr_ptr=1.
//  2. All 3 sources hold 2-beat frames continuously.
//     -> grant order 001,010,100,001; no interleaved beats; 1 idle cycle between frames.
//  3. m_tready toggles 1,0,1,0 during a 4-beat src1 frame.
//     -> m_tdata/m_tkeep stable on stalled cycles; exactly 4 transfers; s_tready[1] mirrors m_tready.
//  4. MAX_BEATS=4, src2 sends a 7-beat frame.
//     -> 4 beats out, 4th has m_tlast=1; beats 5-7 absorbed with m_tvalid=0; trunc_pulse once; trunc_cnt=1.
//  5. Assert eth_rst_n=0 on beat 2 of a src0 frame.
//     -> all outputs 0 immediately; after release, src1 request gets grant=010 (rr_ptr=0, src0 idle).
//  6. src0 drops s_tvalid for 2 cycles mid-frame while src1 requests.
//     -> grant stays 001 until src0 tlast, then 010.

Source files
------------

// File: rtl/eth_tx_arb.sv
// Packet-atomic round-robin arbiter sharing one 64-bit Ethernet TX AXI-stream among NUM_SRC sources.
// Frames longer than MAX_BEATS are cut with a forced tlast and the remainder of the source frame is dropped.
//
// state | meaning
// IDLE  | no owner; pick the next requester in rr_ptr order
// PASS  | owner's beats forwarded to the MAC
// DRAIN | owner's frame was truncated; its remaining beats are discarded

module eth_tx_arb #(
  parameter int NUM_SRC   = 3,
  parameter int MAX_BEATS = 190
) (
  input  logic                   eth_clk,
  input  logic                   eth_rst_n,
  input  logic [NUM_SRC-1:0]     s_tvalid,
  input  logic [NUM_SRC-1:0]     s_tlast,
  input  logic [8*NUM_SRC-1:0]   s_tkeep,
  input  logic [64*NUM_SRC-1:0]  s_tdata,
  output logic [NUM_SRC-1:0]     s_tready,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  output logic [7:0]             m_tkeep,
  output logic [63:0]            m_tdata,
  input  logic                   m_tready,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   trunc_pulse,
  output logic [15:0]            trunc_cnt
);

  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [PTR_W-1:0]   winner, owner_inc;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [NUM_SRC-1:0] grant_nxt;
  logic               any_req, sel_valid, sel_last, at_limit, trunc_nxt;
  logic [7:0]         sel_keep;
  logic [63:0]        sel_data;

  // First requester at or after ptr, wrapping modulo NUM_SRC.
  function automatic logic [PTR_W-1:0] pick_winner(input logic [NUM_SRC-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = idx[PTR_W-1:0];
      end
    end
    return w;
  endfunction

  assign any_req   = |s_tvalid;
  assign winner    = pick_winner(s_tvalid, rr_ptr);
  assign owner_inc = (owner == PTR_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;

  assign sel_valid = s_tvalid[owner];
  assign sel_last  = s_tlast[owner];
  assign sel_keep  = s_tkeep[8*owner +: 8];
  assign sel_data  = s_tdata[64*owner +: 64];
  assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      grant       <= '0;
      trunc_pulse <= 1'b0;
      trunc_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner       <= owner_nxt;
      beat_cnt    <= beat_cnt_nxt;
      grant       <= grant_nxt;
      trunc_pulse <= trunc_nxt;
      if (trunc_nxt && (trunc_cnt != 16'hFFFF)) trunc_cnt <= trunc_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    grant_nxt    = grant;
    trunc_nxt    = 1'b0;
    s_tready     = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tkeep      = '0;
    m_tdata      = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt    = winner;
          grant_nxt    = NUM_SRC'(1) << winner;
          beat_cnt_nxt = '0;
          state_nxt    = PASS;
        end
      end
      PASS: begin
        m_tvalid = sel_valid;
        m_tlast  = sel_last | at_limit;
        m_tkeep  = sel_keep;
        m_tdata  = sel_data;
        s_tready = grant & {NUM_SRC{m_tready}};
        if (sel_valid && m_tready) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (sel_last) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = owner_inc;
          end else if (at_limit) begin
            // MAC already saw the forced tlast; discard the rest of this frame
            state_nxt = DRAIN;
            trunc_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        s_tready = grant;
        if (sel_valid && sel_last) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = owner_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
